// File: rtl/mult_pkg.sv
// Shared widths and defaults for the approximate 8x8 multiplier.
// Imported by the core and the wrapper.
package mult_pkg;
   localparam int OPER_W = 8;
   localparam int PROD_W = 16;
   localparam int APPROX_COLS_DEF = 4;
endpackage

// File: rtl/hpam_mul8.sv
// Combinational 8x8 approximate multiplier: exact upper columns,
// OR-compressed lower columns with no carry into the exact part.
module hpam_mul8
   import mult_pkg::*;
#(
   parameter int APPROX_COLS = APPROX_COLS_DEF
) (
   input  logic [OPER_W-1:0] a,
   input  logic [OPER_W-1:0] b,
   output logic [PROD_W-1:0] p
);

   localparam logic [PROD_W-1:0] LO_MASK =
      PROD_W'((32'd1 << APPROX_COLS) - 32'd1);

   logic [PROD_W-1:0] row [OPER_W];
   logic [PROD_W-1:0] acc [OPER_W+1];
   logic [PROD_W-1:0] lo  [OPER_W+1];

   assign acc[0] = '0;
   assign lo[0]  = '0;

   // Row i holds pp[i][j] at bit i+j; columns split by LO_MASK.
   for (genvar i = 0; i < OPER_W; i++) begin : g_row
      assign row[i] =
         PROD_W'(a & {OPER_W{b[i]}}) << i;
      assign acc[i+1] = acc[i] + (row[i] & ~LO_MASK);
      assign lo[i+1]  = lo[i] | (row[i] & LO_MASK);
   end

   // Upper sum has zero low bits, so OR is the carry-free add.
   assign p = acc[OPER_W] | lo[OPER_W];

endmodule

// File: rtl/mult_wrapper.sv
// Two-stage pipelined approximate multiplier: registered operands,
// combinational core, registered product. No handshake.
module mult_wrapper
   import mult_pkg::*;
#(
   parameter int APPROX_COLS = APPROX_COLS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [OPER_W-1:0] inA,
   input  logic [OPER_W-1:0] inB,
   output logic [PROD_W-1:0] Y
);

   logic [OPER_W-1:0] inA_q;
   logic [OPER_W-1:0] inB_q;
   logic [PROD_W-1:0] p;

   always_ff @(posedge clk) begin
      if (reset) begin
         inA_q <= '0;
         inB_q <= '0;
         Y     <= '0;
      end else begin
         inA_q <= inA;
         inB_q <= inB;
         Y     <= p;
      end
   end

   hpam_mul8 #(
      .APPROX_COLS(APPROX_COLS)
   ) u_core (
      .a(inA_q),
      .b(inB_q),
      .p(p)
   );

endmodule

// File: tb/tb_mult_wrapper.sv
// Self-checking bench for mult_wrapper with 4 approximate columns
// and with an exact (0-column) instance sharing the same operands.
module tb_mult_wrapper;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  inA = '0;
   logic [7:0]  inB = '0;
   logic [15:0] y4;
   logic [15:0] y0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mult_wrapper #(.APPROX_COLS(4)) dut4 (
      .clk(clk), .reset(reset),
      .inA(inA), .inB(inB), .Y(y4)
   );

   mult_wrapper #(.APPROX_COLS(0)) dut0 (
      .clk(clk), .reset(reset),
      .inA(inA), .inB(inB), .Y(y0)
   );

   // Column model: exact sum at weight >= n, OR per column below n.
   function automatic logic [15:0] ref_p(
      input logic [7:0] a, input logic [7:0] b, input int n);
      int unsigned u;
      logic [15:0] low;
      u = 0;
      low = '0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            if (b[i] && a[j]) begin
               if (i + j >= n) u += (1 << (i + j));
               else low[i+j] = 1'b1;
            end
      return 16'(u) + low;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      inA = 8'($urandom);
      inB = 8'($urandom);
      step();
      step();
      checks++;
      if (y4 !== 16'd0) begin
         errors++;
         $display("FAIL reset_y4 got %0d want 0", y4);
      end
      checks++;
      if (y0 !== 16'd0) begin
         errors++;
         $display("FAIL reset_y0 got %0d want 0", y0);
      end
      reset = 1'b0;
   endtask

   task automatic test_vectors();
      logic [7:0]  ta [7];
      logic [7:0]  tb [7];
      logic [15:0] te [7];
      ta = '{8'd3, 8'd255, 8'd16, 8'd15, 8'd0, 8'd1, 8'd7};
      tb = '{8'd3, 8'd255, 8'd16, 8'd1, 8'd200, 8'd1, 8'd9};
      te = '{16'd7, 16'd64991, 16'd256, 16'd15,
             16'd0, 16'd1, 16'd63};
      for (int k = 0; k < 7; k++) begin
         inA = ta[k];
         inB = tb[k];
         step();
         step();
         checks++;
         if (y4 !== te[k]) begin
            errors++;
            $display("FAIL vec%0d_approx %0d*%0d got %0d want %0d",
                     k, ta[k], tb[k], y4, te[k]);
         end
         checks++;
         if (y0 !== 16'(ta[k] * tb[k])) begin
            errors++;
            $display("FAIL vec%0d_exact got %0d want %0d",
                     k, y0, ta[k] * tb[k]);
         end
      end
   endtask

   task automatic test_back_to_back(input int n);
      logic [7:0] pa, pb;
      logic [15:0] e4, e0;
      pa = '0;
      pb = '0;
      for (int k = 0; k <= n; k++) begin
         if (k < n) begin
            inA = 8'($urandom);
            inB = 8'($urandom);
         end
         step();
         if (k > 0) begin
            e4 = ref_p(pa, pb, 4);
            e0 = 16'(pa * pb);
            checks++;
            if (y4 !== e4 || y0 !== e0) begin
               errors++;
               $display("FAIL b2b %0d*%0d got %0d/%0d want %0d/%0d",
                        pa, pb, y4, y0, e4, e0);
            end
         end
         pa = inA;
         pb = inB;
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] e;
      inA = 8'd200;
      inB = 8'd100;
      step();
      reset = 1'b1;
      inA = 8'd7;
      inB = 8'd9;
      step();
      checks++;
      if (y4 !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset_flush got %0d want 0", y4);
      end
      reset = 1'b0;
      step();
      checks++;
      if (y4 !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset_stage2 got %0d want 0", y4);
      end
      step();
      e = ref_p(8'd7, 8'd9, 4);
      checks++;
      if (y4 !== e || y0 !== 16'd63) begin
         errors++;
         $display("FAIL mid_reset_7x9 got %0d/%0d want %0d/63",
                  y4, y0, e);
      end
   endtask

   task automatic test_sweep();
      logic [7:0] pa, pb;
      logic [15:0] e4;
      int bad;
      real red_sum;
      int nz;
      bad = 0;
      red_sum = 0.0;
      nz = 0;
      pa = '0;
      pb = '0;
      for (int k = 0; k <= 65536; k++) begin
         if (k < 65536) begin
            inA = 8'(k >> 8);
            inB = 8'(k);
         end
         step();
         if (k > 0) begin
            e4 = ref_p(pa, pb, 4);
            checks++;
            if (y4 !== e4 || y0 !== 16'(pa * pb)) begin
               errors++;
               bad++;
               if (bad <= 10)
                  $display("FAIL sweep %0d*%0d got %0d/%0d want %0d/%0d",
                           pa, pb, y4, y0, e4, pa * pb);
            end
            if (pa * pb != 0) begin
               nz++;
               red_sum += (real'(pa * pb) - real'(y4)) /
                          real'(pa * pb);
            end
         end
         pa = inA;
         pb = inB;
      end
      $display("sweep MRED %f over %0d nonzero pairs",
               red_sum / real'(nz), nz);
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back(200);
      test_reset_mid();
      test_sweep();
      test_back_to_back(100);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_wrapper.md
MULT_WRAPPER -- requirements
Module: mult_wrapper

Interface
REQ-001 Parameter: APPROX_COLS, default 4, number of low-order product columns computed approximately; legal range 0..8, where 0 gives an exact multiplier.
REQ-002 Port: clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1 bit, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 Port: inA, input, 8 bits, unsigned multiplicand.
REQ-005 Port: inB, input, 8 bits, unsigned multiplier.
REQ-006 Port: Y, output, 16 bits, unsigned approximate product, driven directly from the output register.
REQ-007 The block has one clock and a synchronous, active-high reset.

Function
REQ-008 The block is an 8x8 unsigned approximate multiplier with a registered input stage and a registered output stage, and no handshake.
REQ-009 Partial products: pp[i][j] = inB_q[i] AND inA_q[j], for i,j in 0..7, at column weight k = i+j.
REQ-010 Upper part: all pp with k >= APPROX_COLS are summed exactly, with full carry propagation, into a 16-bit value U.
REQ-011 Lower part: for each k < APPROX_COLS, result bit k = OR of all pp in column k.
REQ-012 No carry is generated from the lower columns into column APPROX_COLS.
REQ-013 The combinational product is P = U + (OR bits in positions 0..APPROX_COLS-1).
REQ-014 Because U is a multiple of 2^APPROX_COLS, this addition never carries.
REQ-015 If either operand is 0, P is 0.
REQ-016 P never exceeds 65535; no overflow handling is needed.
REQ-017 Cycle 1: inA and inB are captured into the input registers inA_q and inB_q at a rising edge.
REQ-018 Cycle 2: P, computed from inA_q and inB_q, is captured into the output register at the next rising edge.
REQ-019 Y reflects an operand pair 2 rising edges after that pair is applied, and is stable through cycle 3.
REQ-020 Operands change every cycle and the pipeline accepts a new pair every cycle (throughput 1); there are no stalls.
REQ-021 Y is deterministic: the same operands always produce the same Y.

Reset
REQ-022 While reset is high at a rising edge, inA_q, inB_q and Y are all cleared to 0.
REQ-023 Reset has priority over capture; if operands are applied during the reset edge, they are discarded.
REQ-024 Reset mid-operation flushes both pipeline stages.
REQ-025 After reset, the first valid Y appears 2 edges after reset deasserts and operands are applied.

Structure
REQ-026 Package mult_pkg holds OPER_W=8, PROD_W=16 and the default APPROX_COLS=4.
REQ-027 The combinational approximate core is one sub-module, hpam_mul8 (inputs a, b; output p), with no clock.
REQ-028 mult_wrapper contains only the input registers, the output register and the hpam_mul8 instance.
REQ-029 The partial-product array and the column compression are built with generate loops; behavioural "*" is not used in the core.

Verification
REQ-030 With APPROX_COLS=4: inA=3, inB=3 -> Y=7 (exact product 9), 2 edges later.
REQ-031 inA=255, inB=255 -> Y=64991 (exact 65025); inA=16, inB=16 -> Y=256 (exact).
REQ-032 inA=15, inB=1 -> Y=15; inA=0, inB=200 -> Y=0; inA=1, inB=1 -> Y=1.
REQ-033 Exhaustive sweep of all 65536 pairs, one pair per cycle: Y matches a reference model of REQ-009..REQ-014.
REQ-034 The same sweep reports mean relative error distance, with zero-product pairs excluded from the division.
REQ-035 Reset asserted for one edge between pairs (A=200,B=100) and (A=7,B=9) -> Y=0 on the next edge, then Y for (7,9) 2 edges after reset release.
REQ-036 With APPROX_COLS=0: random pairs -> Y equals the exact product inA*inB.
